// File: rtl/thor2024_uop_expander_pkg.sv
// Shared types and helpers for the stack macro-op expander.
// THOR_UOP_ENTER_LEAVE_EN enables ENTER/LEAVE expansion.
package thor2024_uop_expander_pkg;

  localparam int SP_REG     = 31;
  localparam int FP_REG     = 30;
  localparam int LR_REG     = 29;
  localparam int WORD_BYTES = 8;
  localparam int PCW        = 32;
  localparam int IMMW       = 15;

  typedef enum logic [6:0] {
    OP_NOP   = 7'h00,
    OP_ADD   = 7'h04,
    OP_ADDI  = 7'h05,
    OP_PFX   = 7'h08,
    OP_ATOM  = 7'h09,
    OP_LDO   = 7'h10,
    OP_STO   = 7'h18,
    OP_PUSH  = 7'h20,
    OP_POP   = 7'h21,
    OP_ENTER = 7'h22,
    OP_LEAVE = 7'h23
  } opcode_t;

  typedef struct packed {
    logic [IMMW-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    opcode_t         op;
  } instruction_t;

  typedef enum logic {
    IDLE,
    EXPAND
  } uop_state_t;

  // PUSH/POP: cnt in [8:7], register list R0..R3 in [13:9],[18:14],[23:19],[28:24]
  function automatic logic [1:0] fnRegCnt(instruction_t i);
    return i.rd[1:0];
  endfunction

  function automatic logic [4:0] fnReg(instruction_t i, logic [1:0] k);
    logic [31:0] w;
    int unsigned b;
    w = i;
    b = 9 + 5 * int'(k);
    return w[b +: 5];
  endfunction

  function automatic instruction_t fnMk(opcode_t op, logic [4:0] rd,
                                        logic [4:0] rs1,
                                        logic [IMMW-1:0] imm);
    instruction_t r;
    r.op  = op;
    r.rd  = rd;
    r.rs1 = rs1;
    r.imm = imm;
    return r;
  endfunction

  function automatic logic [2:0] fnUopCount(instruction_t i);
    logic [2:0] n;
    n = 3'd1;
    unique case (1'b1)
      i.op == OP_PUSH,
      i.op == OP_POP:   n = {1'b0, fnRegCnt(i)} + 3'd2;
`ifdef THOR_UOP_ENTER_LEAVE_EN
      i.op == OP_ENTER: n = 3'd5;
      i.op == OP_LEAVE: n = 3'd4;
`endif
      default:          n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/thor2024_uop_expander_if.sv
// Align-to-decode handshake bundle around the uop expander.
// The slave modport is the expander's view.
interface thor2024_uop_expander_if;
  import thor2024_uop_expander_pkg::*;

  logic             in_valid;
  logic             in_ready;
  instruction_t     in_instr;
  logic [PCW-1:0]   in_pc;
  logic             out_valid;
  logic             out_ready;
  instruction_t     out_instr;
  logic [PCW-1:0]   out_pc;
  logic [2:0]       out_uop_idx;
  logic             out_last;
  logic             out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc,
    output out_uop_idx, out_last, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc,
    input  out_uop_idx, out_last, out_illegal
  );
endinterface

// File: rtl/thor2024_uop_gen.sv
// Combinational micro-op generator: (instr, idx) -> uop.
// THOR_UOP_ENTER_LEAVE_EN enables ENTER/LEAVE sequences.
module thor2024_uop_gen
  import thor2024_uop_expander_pkg::*;
(
  input  instruction_t instr_i,
  input  logic [2:0]   idx_i,
  output instruction_t uop_o
);

  localparam logic [4:0] SP = 5'(SP_REG);
`ifdef THOR_UOP_ENTER_LEAVE_EN
  localparam logic [4:0] FP = 5'(FP_REG);
  localparam logic [4:0] LR = 5'(LR_REG);
`endif
  localparam logic [IMMW-1:0] WB = IMMW'(WORD_BYTES);

  logic [2:0]      n;
  logic [1:0]      k;
  logic [IMMW-1:0] nb;

  always_comb begin
    n     = {1'b0, fnRegCnt(instr_i)} + 3'd1;
    k     = 2'(idx_i - 3'd1);
    nb    = WB * IMMW'(n);
    uop_o = instr_i;
    unique case (1'b1)
      instr_i.op == OP_PUSH: begin
        if (idx_i == 3'd0)
          uop_o = fnMk(OP_ADDI, SP, SP, -nb);
        else
          uop_o = fnMk(OP_STO, fnReg(instr_i, k), SP,
                       WB * IMMW'(n - 3'd1 - {1'b0, k}));
      end
      instr_i.op == OP_POP: begin
        if (idx_i < n)
          uop_o = fnMk(OP_LDO, fnReg(instr_i, idx_i[1:0]), SP,
                       WB * IMMW'(n - 3'd1 - idx_i));
        else
          uop_o = fnMk(OP_ADDI, SP, SP, nb);
      end
`ifdef THOR_UOP_ENTER_LEAVE_EN
      instr_i.op == OP_ENTER: begin
        unique case (idx_i)
          3'd0:    uop_o = fnMk(OP_ADDI, SP, SP, -(WB * 2));
          3'd1:    uop_o = fnMk(OP_STO, FP, SP, '0);
          3'd2:    uop_o = fnMk(OP_STO, LR, SP, WB);
          3'd3:    uop_o = fnMk(OP_ADDI, FP, SP, '0);
          default: uop_o = fnMk(OP_ADDI, SP, SP, -instr_i.imm);
        endcase
      end
      instr_i.op == OP_LEAVE: begin
        unique case (idx_i)
          3'd0:    uop_o = fnMk(OP_ADDI, SP, FP, '0);
          3'd1:    uop_o = fnMk(OP_LDO, FP, SP, '0);
          3'd2:    uop_o = fnMk(OP_LDO, LR, SP, WB);
          default: uop_o = fnMk(OP_ADDI, SP, SP, WB * 2 + instr_i.imm);
        endcase
      end
`endif
      default: uop_o = instr_i;
    endcase
  end

endmodule

// File: rtl/thor2024_uop_expander.sv
// Stack macro-op expander between align and decode.
// THOR_UOP_ENTER_LEAVE_EN enables ENTER/LEAVE expansion.
module thor2024_uop_expander
  import thor2024_uop_expander_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  thor2024_uop_expander_if.slave  io
);

  uop_state_t     state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     num_q, num_d;
  instruction_t   mac_q, mac_d;
  logic [PCW-1:0] pc_q, pc_d;

  logic           ov_q, ov_d;
  instruction_t   oi_q, oi_d;
  logic [PCW-1:0] opc_q, opc_d;
  logic [2:0]     idx_q, idx_d;
  logic           last_q, last_d;
  logic           ill_q, ill_d;

  logic           in_ready;
  logic           accept;
  logic [2:0]     in_n;
  logic           in_ill;
  logic           exp_last;
  instruction_t   gen_in;
  logic [2:0]     gen_idx;
  instruction_t   gen_uop;

  assign in_ready = (state_q == IDLE) && (!ov_q || io.out_ready);
  assign accept   = io.in_valid && in_ready;
  assign in_n     = fnUopCount(io.in_instr);
  assign exp_last = (cnt_q == num_q - 3'd1);
  assign gen_in   = (state_q == IDLE) ? io.in_instr : mac_q;
  assign gen_idx  = (state_q == IDLE) ? 3'd0 : cnt_q;

`ifdef THOR_UOP_ENTER_LEAVE_EN
  assign in_ill = 1'b0;
`else
  assign in_ill = (io.in_instr.op == OP_ENTER) ||
                  (io.in_instr.op == OP_LEAVE);
`endif

  thor2024_uop_gen u_gen (
    .instr_i (gen_in),
    .idx_i   (gen_idx),
    .uop_o   (gen_uop)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    mac_d   = mac_q;
    pc_d    = pc_q;
    ov_d    = ov_q;
    oi_d    = oi_q;
    opc_d   = opc_q;
    idx_d   = idx_q;
    last_d  = last_q;
    ill_d   = ill_q;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
      idx_d   = '0;
      last_d  = 1'b0;
      ill_d   = 1'b0;
    end else if (state_q == EXPAND) begin
      // out_valid stays high for the whole sequence
      if (io.out_ready) begin
        ov_d   = 1'b1;
        oi_d   = gen_uop;
        opc_d  = pc_q;
        idx_d  = cnt_q;
        last_d = exp_last;
        ill_d  = 1'b0;
        cnt_d  = cnt_q + 3'd1;
        if (exp_last) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end else begin
      if (ov_q && io.out_ready)
        ov_d = 1'b0;
      if (accept) begin
        ov_d   = 1'b1;
        oi_d   = gen_uop;
        opc_d  = io.in_pc;
        idx_d  = '0;
        last_d = (in_n == 3'd1);
        ill_d  = in_ill;
        cnt_d  = '0;
        if (in_n != 3'd1) begin
          state_d = EXPAND;
          cnt_d   = 3'd1;
          num_d   = in_n;
          mac_d   = io.in_instr;
          pc_d    = io.in_pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      mac_q   <= '0;
      pc_q    <= '0;
      ov_q    <= 1'b0;
      oi_q    <= '0;
      opc_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      mac_q   <= mac_d;
      pc_q    <= pc_d;
      ov_q    <= ov_d;
      oi_q    <= oi_d;
      opc_q   <= opc_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      ill_q   <= ill_d;
    end
  end

  assign io.in_ready    = in_ready;
  assign io.out_valid   = ov_q;
  assign io.out_instr   = oi_q;
  assign io.out_pc      = opc_q;
  assign io.out_uop_idx = idx_q;
  assign io.out_last    = last_q;
  assign io.out_illegal = ill_q;

endmodule

// File: tb/tb_thor2024_uop_expander.sv
// Scoreboard bench for the uop expander.
// ENTER/LEAVE vectors follow THOR_UOP_ENTER_LEAVE_EN.
module tb_thor2024_uop_expander;
  import thor2024_uop_expander_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush_i;

  thor2024_uop_expander_if bus();

  thor2024_uop_expander dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush_i),
    .io      (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    instruction_t i;
    logic [31:0]  pc;
    logic [2:0]   idx;
    logic         last;
    logic         ill;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  function automatic instruction_t mk(opcode_t op, int rd, int rs1,
                                      logic [14:0] imm);
    instruction_t r;
    r.op  = op;
    r.rd  = 5'(rd);
    r.rs1 = 5'(rs1);
    r.imm = imm;
    return r;
  endfunction

  function automatic instruction_t mk_list(opcode_t op, int cnt, int r0,
                                           int r1, int r2, int r3);
    logic [31:0] w;
    w        = '0;
    w[6:0]   = op;
    w[8:7]   = 2'(cnt);
    w[13:9]  = 5'(r0);
    w[18:14] = 5'(r1);
    w[23:19] = 5'(r2);
    w[28:24] = 5'(r3);
    return instruction_t'(w);
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic expect_uop(instruction_t i, logic [31:0] pc,
                            int idx, logic last, logic ill);
    exp_t e;
    e.i    = i;
    e.pc   = pc;
    e.idx  = 3'(idx);
    e.last = last;
    e.ill  = ill;
    sb.push_back(e);
  endtask

  // Monitor: pops on every output transfer and checks stall stability
  logic         stall_pend = 1'b0;
  logic         flush_prev = 1'b0;
  logic [68:0]  held;
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_pend && !flush_prev)
        chk("stall_hold",
            {bus.out_valid, bus.out_instr, bus.out_pc,
             bus.out_uop_idx, bus.out_last},
            {1'b1, held[68:1]});
      stall_pend = bus.out_valid && !bus.out_ready;
      held = {bus.out_instr, bus.out_pc, bus.out_uop_idx,
              bus.out_last, bus.out_illegal};
      flush_prev = flush_i;
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_uop actual=%h required=none",
                   bus.out_instr);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("uop",
              {bus.out_instr, bus.out_pc, bus.out_uop_idx,
               bus.out_last, bus.out_illegal},
              {e.i, e.pc, e.idx, e.last, e.ill});
        end
      end
    end
  end

  task automatic send(instruction_t i, logic [31:0] pc, output int waited);
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_instr = i;
    bus.in_pc    = pc;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accept");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 128'(sb.size()), 128'd0);
  endtask

  task automatic toggle_ready(int cycles);
    for (int t = 0; t < cycles; t++) begin
      bus.out_ready = ~bus.out_ready;
      @(posedge clk);
      #1;
    end
  endtask

  int w;
  instruction_t a0, a1, a2, m;

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs",
        {bus.out_valid, bus.out_last, bus.out_illegal, bus.out_uop_idx},
        {1'b0, 1'b0, 1'b0, 3'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;

    // 1: pass-through stream
    a0 = mk(OP_ADD, 1, 2, 15'd3);
    a1 = mk(OP_ADD, 4, 5, 15'd6);
    a2 = mk(OP_PFX, 0, 0, 15'h1234);
    expect_uop(a0, 32'h10, 0, 1'b1, 1'b0);
    expect_uop(a1, 32'h14, 0, 1'b1, 1'b0);
    expect_uop(a2, 32'h18, 0, 1'b1, 1'b0);
    send(a0, 32'h10, w);
    chk("lat_valid", {bus.out_valid, bus.out_instr}, {1'b1, a0});
    send(a1, 32'h14, w);
    chk("stream_wait1", 128'(w), 128'd0);
    send(a2, 32'h18, w);
    chk("stream_wait2", 128'(w), 128'd0);
    drain();

    // 2: PUSH {R5,R6,R7}
    m = mk_list(OP_PUSH, 2, 5, 6, 7, 0);
    expect_uop(mk(OP_ADDI, 31, 31, 15'h7FE8), 32'h100, 0, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 5, 31, 15'd16), 32'h100, 1, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 6, 31, 15'd8), 32'h100, 2, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 7, 31, 15'd0), 32'h100, 3, 1'b1, 1'b0);
    send(m, 32'h100, w);
    drain();

    // 3: PUSH {R1..R4} with out_ready toggling
    m = mk_list(OP_PUSH, 3, 1, 2, 3, 4);
    expect_uop(mk(OP_ADDI, 31, 31, 15'h7FE0), 32'h200, 0, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 1, 31, 15'd24), 32'h200, 1, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 2, 31, 15'd16), 32'h200, 2, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 3, 31, 15'd8), 32'h200, 3, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 4, 31, 15'd0), 32'h200, 4, 1'b1, 1'b0);
    send(m, 32'h200, w);
    toggle_ready(12);
    drain();

`ifdef THOR_UOP_ENTER_LEAVE_EN
    m = mk(OP_ENTER, 0, 0, 15'd64);
    expect_uop(mk(OP_ADDI, 31, 31, 15'h7FF0), 32'h240, 0, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 30, 31, 15'd0), 32'h240, 1, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 29, 31, 15'd8), 32'h240, 2, 1'b0, 1'b0);
    expect_uop(mk(OP_ADDI, 30, 31, 15'd0), 32'h240, 3, 1'b0, 1'b0);
    expect_uop(mk(OP_ADDI, 31, 31, 15'h7FC0), 32'h240, 4, 1'b1, 1'b0);
    send(m, 32'h240, w);
    toggle_ready(12);
    drain();
    m = mk(OP_LEAVE, 0, 0, 15'd16);
    expect_uop(mk(OP_ADDI, 31, 30, 15'd0), 32'h280, 0, 1'b0, 1'b0);
    expect_uop(mk(OP_LDO, 30, 31, 15'd0), 32'h280, 1, 1'b0, 1'b0);
    expect_uop(mk(OP_LDO, 29, 31, 15'd8), 32'h280, 2, 1'b0, 1'b0);
    expect_uop(mk(OP_ADDI, 31, 31, 15'd32), 32'h280, 3, 1'b1, 1'b0);
    send(m, 32'h280, w);
    drain();
`else
    // 6: ENTER/LEAVE pass through flagged illegal
    m = mk(OP_LEAVE, 0, 0, 15'd16);
    expect_uop(m, 32'h280, 0, 1'b1, 1'b1);
    send(m, 32'h280, w);
    m = mk(OP_ENTER, 0, 0, 15'd64);
    expect_uop(m, 32'h284, 0, 1'b1, 1'b1);
    send(m, 32'h284, w);
    drain();
`endif

    // 4: POP {R8,R9} then ADD without a bubble
    m = mk_list(OP_POP, 1, 8, 9, 0, 0);
    a0 = mk(OP_ADD, 3, 3, 15'd1);
    expect_uop(mk(OP_LDO, 8, 31, 15'd8), 32'h300, 0, 1'b0, 1'b0);
    expect_uop(mk(OP_LDO, 9, 31, 15'd0), 32'h300, 1, 1'b0, 1'b0);
    expect_uop(mk(OP_ADDI, 31, 31, 15'd16), 32'h300, 2, 1'b1, 1'b0);
    expect_uop(a0, 32'h304, 0, 1'b1, 1'b0);
    send(m, 32'h300, w);
    send(a0, 32'h304, w);
    chk("pop_in_ready_wait", 128'(w), 128'd2);
    chk("no_bubble", {bus.out_valid, bus.out_instr, bus.out_pc},
        {1'b1, a0, 32'h304});
    drain();

    // 5: flush while PUSH uop 2 is presented
    m = mk_list(OP_PUSH, 2, 10, 11, 12, 0);
    expect_uop(mk(OP_ADDI, 31, 31, 15'h7FE8), 32'h400, 0, 1'b0, 1'b0);
    expect_uop(mk(OP_STO, 10, 31, 15'd16), 32'h400, 1, 1'b0, 1'b0);
    send(m, 32'h400, w);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_flush_idx", 128'(bus.out_uop_idx), 128'd2);
    bus.out_ready = 1'b0;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    chk("post_flush",
        {bus.out_valid, bus.in_ready, bus.out_uop_idx, bus.out_last},
        {1'b0, 1'b1, 3'd0, 1'b0});
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
